// File: rtl/obi_pkg.sv
// Shared OBI definitions used by the 4-to-1 arbiter and the 1-to-N address demux.
package obi_pkg;

   localparam int          OBI_ID_W      = 2;
   localparam logic [31:0] OBI_ERR_RDATA = 32'hDEADBEEF;

   typedef logic [OBI_ID_W-1:0] obi_owner_t;

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order record of which master owns each outstanding read.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module obi_owner_fifo
   import obi_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push,
   input  logic       pop,
   input  obi_owner_t din,
   output logic       full,
   output logic       empty,
   output obi_owner_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   obi_owner_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // NOTE: the storage array is deliberately not reset; count and pointers alone say which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/obi_arbiter_4_to_1.sv
// Round-robin arbiter sharing one OBI slave among four masters, with in-order read routing.
// Define OBI_ARB_TIMEOUT_EN to build the read-response watchdog.
module obi_arbiter_4_to_1
   import obi_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   input  logic        m2_req_i,
   output logic        m2_gnt_o,
   input  logic [31:0] m2_addr_i,
   input  logic        m2_we_i,
   input  logic [3:0]  m2_be_i,
   input  logic [31:0] m2_wdata_i,
   output logic        m2_rvalid_o,
   output logic [31:0] m2_rdata_o,
   input  logic        m3_req_i,
   output logic        m3_gnt_o,
   input  logic [31:0] m3_addr_i,
   input  logic        m3_we_i,
   input  logic [3:0]  m3_be_i,
   input  logic [31:0] m3_wdata_i,
   output logic        m3_rvalid_o,
   output logic [31:0] m3_rdata_o,
   output logic        slave_req_o,
   input  logic        slave_gnt_i,
   output logic [31:0] slave_addr_o,
   output logic        slave_we_o,
   output logic [3:0]  slave_be_o,
   output logic [31:0] slave_wdata_o,
   input  logic        slave_rvalid_i,
   input  logic [31:0] slave_rdata_i,
   output logic        spurious_o,
   output logic        timeout_o
);

   logic [3:0]  req;
   logic [3:0]  we;
   logic [31:0] addr  [4];
   logic [3:0]  be    [4];
   logic [31:0] wdata [4];
   logic [31:0] rdata [4];
   logic [3:0]  gnt_vec;
   logic [3:0]  rvalid_vec;

   obi_owner_t  rr_ptr;
   obi_owner_t  hold_id;
   obi_owner_t  rr_win;
   obi_owner_t  winner;
   obi_owner_t  head;
   logic        hold_vld;
   logic        rr_found;
   logic        fifo_full;
   logic        fifo_empty;
   logic        hs;
   logic        push;
   logic        pop;
   logic        resp_real;
   logic        timeout_fire;
   logic [31:0] resp_data;

   assign req   = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
   assign we    = {m3_we_i, m2_we_i, m1_we_i, m0_we_i};
   assign addr  = '{m0_addr_i, m1_addr_i, m2_addr_i, m3_addr_i};
   assign be    = '{m0_be_i, m1_be_i, m2_be_i, m3_be_i};
   assign wdata = '{m0_wdata_i, m1_wdata_i, m2_wdata_i, m3_wdata_i};

   // Search starts at rr_ptr; the 2-bit sum wraps naturally. Falls back to master 0 when idle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      rr_win   = '0;
      rr_found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!rr_found && req[rr_ptr + obi_owner_t'(k)]) begin
            rr_win   = rr_ptr + obi_owner_t'(k);
            rr_found = 1'b1;
         end
      end
   end

   assign winner      = (hold_vld && req[hold_id]) ? hold_id : rr_win;
   assign slave_req_o = req[winner] & (we[winner] | ~fifo_full) & ~rst_i;
   assign hs          = slave_req_o & slave_gnt_i;
   assign push        = hs & ~we[winner];

   assign slave_addr_o  = addr[winner];
   assign slave_we_o    = we[winner];
   assign slave_be_o    = be[winner];
   assign slave_wdata_o = wdata[winner];

   assign resp_real  = slave_rvalid_i & ~fifo_empty & ~rst_i;
   assign pop        = resp_real | timeout_fire;
   assign resp_data  = resp_real ? slave_rdata_i : OBI_ERR_RDATA;
   assign spurious_o = slave_rvalid_i & fifo_empty & ~rst_i;

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         gnt_vec[n]    = hs && (winner == obi_owner_t'(n));
         rvalid_vec[n] = pop && (head == obi_owner_t'(n));
         rdata[n]      = rvalid_vec[n] ? resp_data : '0;
      end
   end

   assign {m3_gnt_o, m2_gnt_o, m1_gnt_o, m0_gnt_o}             = gnt_vec;
   assign {m3_rvalid_o, m2_rvalid_o, m1_rvalid_o, m0_rvalid_o} = rvalid_vec;
   assign m0_rdata_o = rdata[0];
   assign m1_rdata_o = rdata[1];
   assign m2_rdata_o = rdata[2];
   assign m3_rdata_o = rdata[3];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr   <= '0;
         hold_vld <= 1'b0;
         hold_id  <= '0;
      end else begin
         if (hs) rr_ptr <= winner + 1'b1;
         hold_vld <= slave_req_o & ~slave_gnt_i;
         hold_id  <= winner;
      end
   end

   obi_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .din   (winner),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

`ifdef OBI_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // A real response in the firing cycle takes priority over the synthetic error response.
   assign timeout_fire = ~rst_i & ~fifo_empty & ~slave_rvalid_i &
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o    = timeout_fire;

   always_ff @(posedge clk_i) begin
      if (rst_i || pop || fifo_empty) wd_cnt <= '0;
      else                            wd_cnt <= wd_cnt + 1'b1;
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_fire       = 1'b0;
   assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_obi_arbiter_4_to_1.sv
// Scoreboard bench for obi_arbiter_4_to_1: directed scenarios followed by randomized traffic.
module tb_obi_arbiter_4_to_1;

   localparam int MO = 2;
   localparam int TO = 10;

   typedef struct packed {
      logic             chk_data;
      logic             sreq;
      logic [3:0]       gnt;
      logic [31:0]      addr;
      logic             we;
      logic [3:0]       be;
      logic [31:0]      wdata;
      logic [3:0]       rvalid;
      logic [3:0][31:0] rdata;
      logic             spur;
      logic             tmo;
   } exp_t;

   typedef struct packed {
      logic [1:0]  owner;
      logic [31:0] data;
   } pend_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  m_req, m_we, m_gnt, m_rvalid;
   logic [31:0] m_addr  [4];
   logic [3:0]  m_be    [4];
   logic [31:0] m_wdata [4];
   logic [31:0] m_rdata [4];
   logic        slave_req_o, slave_gnt_i, slave_we_o, slave_rvalid_i;
   logic [31:0] slave_addr_o, slave_wdata_o, slave_rdata_i;
   logic [3:0]  slave_be_o;
   logic        spurious_o, timeout_o;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_cyc   = 0;
   int    rr      = 0;
   int    hold_id = 0;
   int    wd      = 0;
   bit    hold_v  = 0;
   bit    directed_data = 0;
   pend_t pend_q [$];
   exp_t  exp_q  [$];

   always #5 clk_i = ~clk_i;

   obi_arbiter_4_to_1 #(
      .MAX_OUTSTANDING (MO),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .m0_req_i       (m_req[0]),   .m0_gnt_o    (m_gnt[0]),    .m0_addr_i  (m_addr[0]),
      .m0_we_i        (m_we[0]),    .m0_be_i     (m_be[0]),     .m0_wdata_i (m_wdata[0]),
      .m0_rvalid_o    (m_rvalid[0]),.m0_rdata_o  (m_rdata[0]),
      .m1_req_i       (m_req[1]),   .m1_gnt_o    (m_gnt[1]),    .m1_addr_i  (m_addr[1]),
      .m1_we_i        (m_we[1]),    .m1_be_i     (m_be[1]),     .m1_wdata_i (m_wdata[1]),
      .m1_rvalid_o    (m_rvalid[1]),.m1_rdata_o  (m_rdata[1]),
      .m2_req_i       (m_req[2]),   .m2_gnt_o    (m_gnt[2]),    .m2_addr_i  (m_addr[2]),
      .m2_we_i        (m_we[2]),    .m2_be_i     (m_be[2]),     .m2_wdata_i (m_wdata[2]),
      .m2_rvalid_o    (m_rvalid[2]),.m2_rdata_o  (m_rdata[2]),
      .m3_req_i       (m_req[3]),   .m3_gnt_o    (m_gnt[3]),    .m3_addr_i  (m_addr[3]),
      .m3_we_i        (m_we[3]),    .m3_be_i     (m_be[3]),     .m3_wdata_i (m_wdata[3]),
      .m3_rvalid_o    (m_rvalid[3]),.m3_rdata_o  (m_rdata[3]),
      .slave_req_o    (slave_req_o),
      .slave_gnt_i    (slave_gnt_i),
      .slave_addr_o   (slave_addr_o),
      .slave_we_o     (slave_we_o),
      .slave_be_o     (slave_be_o),
      .slave_wdata_o  (slave_wdata_o),
      .slave_rvalid_i (slave_rvalid_i),
      .slave_rdata_i  (slave_rdata_i),
      .spurious_o     (spurious_o),
      .timeout_o      (timeout_o)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, n_cyc, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slave_req", 128'(slave_req_o), 128'(e.sreq));
            check("grant",     128'(m_gnt),       128'(e.gnt));
            check("rvalid",    128'(m_rvalid),    128'(e.rvalid));
            check("rdata", {m_rdata[3], m_rdata[2], m_rdata[1], m_rdata[0]}, e.rdata);
            check("spurious",  128'(spurious_o),  128'(e.spur));
            check("timeout",   128'(timeout_o),   128'(e.tmo));
            if (e.chk_data)
               check("payload", 128'({slave_addr_o, slave_we_o, slave_be_o, slave_wdata_o}),
                     128'({e.addr, e.we, e.be, e.wdata}));
            n_cyc++;
         end
      end
   end

   task automatic req_m(input int n, input bit we_b);
      m_req[n]   = 1'b1;
      m_we[n]    = we_b;
      m_addr[n]  = $urandom;
      m_be[n]    = 4'($urandom);
      m_wdata[n] = $urandom;
   endtask

   // One clock cycle: predict outputs from the reference model, queue them, then advance the model.
   task automatic step(input bit rst, output bit hs, output int win);
      exp_t        e;
      bit          found, pop_now, pre_empty;
      int          idx;
      logic [31:0] d;
      rst_i         = rst;
      slave_rdata_i = (slave_rvalid_i && pend_q.size() > 0 && !rst) ? pend_q[0].data : $urandom;
      e = '0; hs = 0; win = 0; pop_now = 0;
      pre_empty = (pend_q.size() == 0);
      if (!rst) begin
         if (hold_v && m_req[hold_id]) win = hold_id;
         else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               idx = (rr + k) % 4;
               if (!found && m_req[idx]) begin win = idx; found = 1; end
            end
         end
         e.chk_data = 1'b1;
         e.sreq     = m_req[win] && (m_we[win] || pend_q.size() < MO);
         hs         = e.sreq && slave_gnt_i;
         if (hs) e.gnt[win] = 1'b1;
         e.addr = m_addr[win]; e.we = m_we[win]; e.be = m_be[win]; e.wdata = m_wdata[win];
         if (slave_rvalid_i && !pre_empty) begin
            e.rvalid[pend_q[0].owner] = 1'b1;
            e.rdata[pend_q[0].owner]  = pend_q[0].data;
            pop_now = 1;
         end else if (slave_rvalid_i) begin
            e.spur = 1'b1;
         end
`ifdef OBI_ARB_TIMEOUT_EN
         else if (!pre_empty && wd == TO - 1) begin
            e.rvalid[pend_q[0].owner] = 1'b1;
            e.rdata[pend_q[0].owner]  = 32'hDEADBEEF;
            e.tmo = 1'b1;
            pop_now = 1;
         end
`endif
      end
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      if (rst) begin
         rr = 0; hold_v = 0; hold_id = 0; wd = 0;
         pend_q.delete();
      end else begin
         if (pop_now) void'(pend_q.pop_front());
         if (hs && !m_we[win]) begin
            d = directed_data ? 32'hA0 + 32'(win) : $urandom;
            pend_q.push_back(pend_t'{owner: 2'(win), data: d});
         end
         hold_v  = e.sreq && !slave_gnt_i;
         hold_id = win;
         if (hs) rr = (win + 1) % 4;
         wd = (pop_now || pre_empty) ? 0 : wd + 1;
      end
   endtask

   initial begin
      bit hs;
      int win;
      rst_i = 1'b1; m_req = '0; m_we = '0;
      slave_gnt_i = 1'b0; slave_rvalid_i = 1'b0; slave_rdata_i = '0;
      for (int n = 0; n < 4; n++) begin m_addr[n] = '0; m_be[n] = '0; m_wdata[n] = '0; end
      @(posedge clk_i);
      #1;

      // m0/m2 stream reads, response one cycle after each grant.
      directed_data = 1;
      step(1, hs, win); step(1, hs, win);
      req_m(0, 0); req_m(2, 0); slave_gnt_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         slave_rvalid_i = (pend_q.size() > 0);
         step(0, hs, win);
         if (hs) req_m(win, 0);
      end
      m_req = '0;
      for (int c = 0; c < 4 && pend_q.size() > 0; c++) begin slave_rvalid_i = 1'b1; step(0, hs, win); end
      slave_rvalid_i = 1'b0;

      // m1 held through 3 stalled cycles while m3 waits.
      step(1, hs, win);
      req_m(1, 0); req_m(3, 0);
      for (int c = 0; c < 5; c++) begin
         slave_gnt_i = (c >= 3);
         step(0, hs, win);
         if (hs) m_req[win] = 1'b0;
      end
      for (int c = 0; c < 4 && pend_q.size() > 0; c++) begin slave_rvalid_i = 1'b1; step(0, hs, win); end
      slave_rvalid_i = 1'b0;

      // Tracker full: third read blocked, write still passes, then a spurious response.
      step(1, hs, win);
      req_m(0, 0); req_m(1, 0); req_m(2, 0); slave_gnt_i = 1'b1;
      for (int c = 0; c < 4; c++) begin step(0, hs, win); if (hs) m_req[win] = 1'b0; end
      slave_rvalid_i = 1'b1; step(0, hs, win); if (hs) m_req[win] = 1'b0;
      slave_rvalid_i = 1'b0; step(0, hs, win); if (hs) m_req[win] = 1'b0;
      req_m(3, 1); step(0, hs, win); m_req[3] = 1'b0;
      slave_rvalid_i = 1'b1;
      for (int c = 0; c < 3; c++) step(0, hs, win);
      slave_rvalid_i = 1'b0;

`ifdef OBI_ARB_TIMEOUT_EN
      // Unanswered m2 read times out.
      step(1, hs, win);
      req_m(2, 0); step(0, hs, win); m_req = '0;
      for (int c = 0; c < 12; c++) step(0, hs, win);
`endif

      // Reset with a read outstanding, then all four request and a stale response arrives.
      req_m(1, 0); step(0, hs, win); m_req = '0;
      step(0, hs, win);
      step(1, hs, win);
      for (int n = 0; n < 4; n++) req_m(n, 0);
      step(0, hs, win); m_req = '0;
      slave_rvalid_i = 1'b1; step(0, hs, win); step(0, hs, win);
      slave_rvalid_i = 1'b0;

      // Randomized traffic.
      directed_data = 0;
      for (int c = 0; c < 800; c++) begin
         slave_gnt_i    = ($urandom_range(0, 3) != 0);
         slave_rvalid_i = (pend_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
         step(($urandom_range(0, 299) == 0), hs, win);
         for (int n = 0; n < 4; n++) begin
            if (hs && win == n) begin
               if ($urandom_range(0, 1) == 1) req_m(n, 1'($urandom_range(0, 1)));
               else m_req[n] = 1'b0;
            end else if (m_req[n]) begin
               if ($urandom_range(0, 9) == 0) m_req[n] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req_m(n, 1'($urandom_range(0, 1)));
            end
         end
      end

      repeat (2) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/obi_arbiter_4_to_1.md
# obi_arbiter_4_to_1

Round-robin arbiter that shares one OBI slave among four OBI masters. It is the counterpart of the 1-to-N address demux: the two combine into a crossbar, with one arbiter per slave port. It tracks outstanding reads in order, so the slave may pipeline up to `MAX_OUTSTANDING` reads. Each read response returns to the master that issued it.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: depth of the read-owner tracker (1..8).
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only when `OBI_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk_i` in 1: single clock. All state updates on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `mN_req_i` in 1, `mN_gnt_o` out 1, `mN_addr_i` in 32, `mN_we_i` in 1, `mN_be_i` in 4, `mN_wdata_i` in 32, `mN_rvalid_o` out 1, `mN_rdata_o` out 32: master port N, for N = 0..3.
- `slave_req_o` out 1, `slave_gnt_i` in 1, `slave_addr_o` out 32, `slave_we_o` out 1, `slave_be_o` out 4, `slave_wdata_o` out 32, `slave_rvalid_i` in 1, `slave_rdata_i` in 32: the shared slave port.
- `spurious_o` out 1: one-cycle pulse when `slave_rvalid_i` arrives while the tracker is empty.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires. Tied to 0 without the macro.

## Operation
- Winner selection is combinational: the first requesting master at or after `rr_ptr`, searching in increasing index order with wrap.
- Hold: if `slave_req_o` is high and `slave_gnt_i` is low, the winner is registered as `hold_id` and `hold_vld` is set. The next cycle forces the same winner. `hold_vld` clears on handshake, or if the held master drops `req`.
- Admission: a read (`we`=0) is admitted only when the tracker is not full. A read that is not admitted holds `slave_req_o` low. Writes are always admitted and are not tracked; the slave returns no rvalid for writes.
- `slave_req_o` = winner's `req` AND admission. The `addr`/`we`/`be`/`wdata` outputs mux from the winner, or from master 0 when no master requests.
- `mN_gnt_o` = `slave_gnt_i` AND `slave_req_o` AND (winner == N). All other grants are 0.
- Handshake = `slave_req_o` AND `slave_gnt_i`. On a handshake, `rr_ptr` ← winner+1 mod 4. On a read handshake, the winner id (2 bits) is pushed into the owner FIFO.
- Response: `slave_rvalid_i` with a non-empty FIFO routes `rvalid`/`rdata` to the FIFO head owner and pops the head. All other `mN_rvalid_o` stay 0 and the other `rdata` outputs are 0.
- A push and a pop in the same cycle are both performed, so the count is unchanged. Full is evaluated before that cycle's pop: no bypass.
- Reset mid-transaction: the FIFO empties, `rr_ptr`=0 and `hold_vld`=0. Responses still in flight at the slave then arrive as spurious and are dropped.

## Timing
- Request path (master `req` → `slave_req_o`) has zero latency. So do the grant path and the response path.
- The `rr_ptr`, hold and FIFO updates are visible in the cycle after the handshake.
- While `rst_i` is high, `slave_req_o`, all `mN_gnt_o`, all `mN_rvalid_o`, `spurious_o` and `timeout_o` are forced to 0.
- Reset values: `rr_ptr`=0, `hold_vld`=0, FIFO count=0, watchdog=0.
- Throughput: one handshake per cycle while the FIFO has room. Back-to-back reads from different masters are allowed.

## Configuration
- `OBI_ARB_TIMEOUT_EN` defined:
  - A watchdog counter increments each cycle while the FIFO is non-empty. It clears on any pop or when the FIFO is empty.
  - On reaching `TIMEOUT_CYCLES` with no `slave_rvalid_i` that cycle, the block drives `rvalid`=1 and `rdata`=32'hDEADBEEF to the head owner, pops the head and pulses `timeout_o`.
  - A real `slave_rvalid_i` in the same cycle wins over the timeout.
- `OBI_ARB_TIMEOUT_EN` undefined: no counter is built, `timeout_o`=0, and reads wait indefinitely.

## Structure
- Shared `obi_pkg` holds:
  - `OBI_ID_W`=2.
  - `OBI_ERR_RDATA`=32'hDEADBEEF, shared with the demux default response.
  - the `obi_owner_t` typedef.
- One sub-module, `obi_owner_fifo`: synchronous FIFO of `obi_owner_t`, depth `MAX_OUTSTANDING`. It has push/pop/full/empty/head ports and synchronous active-high reset.

## Test plan
- m0 and m2 request reads continuously with `slave_gnt_i`=1 and rvalid 1 cycle later. Required: grants alternate m0, m2, m0. Each master receives its own rdata (0xA0, 0xA2).
- m1 requests with `slave_gnt_i` low for 3 cycles while m3 also requests. Required: m1 stays the winner with addr stable throughout, m1 is granted in cycle 4, then m3 is granted.
- `MAX_OUTSTANDING`=2, three reads from m0/m1/m2 with no rvalid. Required: the third read is blocked (`slave_req_o`=0). After one rvalid, which goes to m0, the third read is granted in the next cycle.
- In the full state, a write from m3 arrives. Required: it is granted immediately and no FIFO push occurs.
- `slave_rvalid_i` with the FIFO empty. Required: `spurious_o` pulses and every `mN_rvalid_o` stays 0.
- With `OBI_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, an m2 read gets no response. Required: in cycle 10, m2 receives rvalid with 0xDEADBEEF, `timeout_o` pulses and the FIFO is empty. Then assert `rst_i` during an outstanding read. Required: the FIFO is empty and `rr_ptr`=0 one cycle later.
